registro_lectura_resultados: RTL and testbench



---
 rtl/registro_lectura_resultados_pkg.sv | 28 ++
 rtl/registro_lectura_resultados_result_fifo.sv | 62 ++++++
 rtl/registro_lectura_resultados.sv | 174 +++++++++++++++++
 tb/tb_registro_lectura_resultados.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/registro_lectura_resultados_pkg.sv
// Shared definitions for the result read-back block: host address map,
// STATUS bit positions, FSM states and default sizes.
package registro_lectura_resultados_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_DEFAULT = 4;

    localparam logic [8:0] ADDR_STATUS   = 9'h040;
    localparam logic [8:0] ADDR_RESULT   = 9'h041;
    localparam logic [8:0] ADDR_PEEK     = 9'h042;
    localparam logic [8:0] ADDR_COUNT    = 9'h043;
    localparam logic [8:0] ADDR_OVFCOUNT = 9'h044;

    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_NOT_EMPTY = 1;
    localparam int STATUS_FULL      = 2;
    localparam int STATUS_OVERFLOW  = 3;
    localparam int STATUS_UNDERFLOW = 4;
    localparam int STATUS_SPURIOUS  = 5;
    localparam int STATUS_BITS      = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RELEASE
    } state_t;

endpackage

// File: rtl/registro_lectura_resultados_result_fifo.sv
// Small synchronous FIFO holding captured results until the host reads them.
// A push while full is only taken when a pop frees a slot in the same cycle;
// a pop while empty does nothing.
module result_fifo #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    output logic [Width-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(Depth));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; written only on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/registro_lectura_resultados.sv
// Read side of the host interface: follows each Start/Done computation,
// captures the datapath result into a FIFO, pulses ResetStart once captured,
// and serves status/results to the host through a one-cycle registered port.
module registro_lectura_resultados
    import registro_lectura_resultados_pkg::*;
#(
    parameter int Width = WIDTH_DEFAULT,
    parameter int Depth = DEPTH_DEFAULT
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Done,
    input  logic [Width-1:0]  Resultado,
    input  logic              Read,
    input  logic [8:0]        Address,
    output logic [Width-1:0]  OutDatoMemoria,
    output logic              ReadValid,
    output logic              ResetStart,
    output logic              Busy,
    output logic              Irq
);

    localparam int CW = $clog2(Depth) + 1;

    state_t                   state;
    logic                     start_prev;
    logic                     overflow;
    logic                     underflow;
    logic                     spurious_done;
    logic [7:0]               ovf_count;

    logic                     push_req;
    logic                     result_rd;
    logic                     status_rd;
    logic                     ovfcount_rd;
    logic                     overflow_set;
    logic                     underflow_set;
    logic                     spurious_set;

    logic [Width-1:0]         fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;

    logic [STATUS_BITS-1:0]   status_bits;
    logic [Width-1:0]         read_data;

    assign push_req      = (state == ST_RUN) && Done;
    assign spurious_set  = Done && (state != ST_RUN);
    assign result_rd     = Read && (Address == ADDR_RESULT);
    assign status_rd     = Read && (Address == ADDR_STATUS);
    assign ovfcount_rd   = Read && (Address == ADDR_OVFCOUNT);
    assign overflow_set  = push_req && fifo_full && !result_rd;
    assign underflow_set = result_rd && fifo_empty;

    assign Irq = !fifo_empty || overflow || underflow || spurious_done;

    result_fifo #(
        .Width (Width),
        .Depth (Depth)
    ) u_result_fifo (
        .clk       (CLK),
        .reset     (Reset),
        .push      (push_req),
        .push_data (Resultado),
        .pop       (result_rd),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Computation lifecycle: start on a rising Start edge, capture on Done,
    // then spend one cycle releasing the start/input registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= ST_IDLE;
            start_prev <= 1'b0;
            Busy       <= 1'b0;
            ResetStart <= 1'b0;
        end else begin
            start_prev <= Start;
            ResetStart <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start && !start_prev) begin
                        state <= ST_RUN;
                        Busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (Done) begin
                        state      <= ST_RELEASE;
                        ResetStart <= 1'b1;
                    end else if (!Start) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags: a new event in the same cycle as a STATUS read wins.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            spurious_done <= 1'b0;
        end else begin
            overflow      <= overflow_set  || (overflow      && !status_rd);
            underflow     <= underflow_set || (underflow     && !status_rd);
            spurious_done <= spurious_set  || (spurious_done && !status_rd);
        end
    end

    // Saturating count of dropped results, cleared when the host reads it.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ovf_count <= 8'd0;
        end else if (ovfcount_rd) begin
            ovf_count <= overflow_set ? 8'd1 : 8'd0;
        end else if (overflow_set && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end

    // STATUS word assembled from the current (pre-update) flag values.
    always_comb begin
        status_bits                   = '0;
        status_bits[STATUS_BUSY]      = Busy;
        status_bits[STATUS_NOT_EMPTY] = !fifo_empty;
        status_bits[STATUS_FULL]      = fifo_full;
        status_bits[STATUS_OVERFLOW]  = overflow;
        status_bits[STATUS_UNDERFLOW] = underflow;
        status_bits[STATUS_SPURIOUS]  = spurious_done;
    end

    // Host read decode; unmapped addresses return zero.
    always_comb begin
        read_data = '0;
        case (Address)
            ADDR_STATUS:   read_data = {{(Width-STATUS_BITS){1'b0}}, status_bits};
            ADDR_RESULT:   read_data = fifo_empty ? '0 : fifo_head;
            ADDR_PEEK:     read_data = fifo_empty ? '0 : fifo_head;
            ADDR_COUNT:    read_data = {{(Width-CW){1'b0}}, fifo_count};
            ADDR_OVFCOUNT: read_data = {{(Width-8){1'b0}}, ovf_count};
            default:       read_data = '0;
        endcase
    end

    // Registered read port; data holds its last value between reads.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            OutDatoMemoria <= '0;
            ReadValid      <= 1'b0;
        end else begin
            ReadValid <= Read;
            if (Read) begin
                OutDatoMemoria <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_registro_lectura_resultados.sv
// Self-checking bench for registro_lectura_resultados: directed scenarios with
// literal expectations, then randomized traffic compared every cycle against
// a queue-based behavioural model.
module tb_registro_lectura_resultados;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Done = 1'b0;
    logic [31:0] Resultado = '0;
    logic        Read = 1'b0;
    logic [8:0]  Address = '0;
    logic [31:0] OutDatoMemoria;
    logic        ReadValid;
    logic        ResetStart;
    logic        Busy;
    logic        Irq;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model state
    logic [31:0] q[$];
    int          m_phase = 0;   // 0 waiting for start, 1 computing, 2 releasing
    bit          m_prev = 0;
    bit          m_busy = 0;
    bit          m_rs = 0;
    bit          m_rv = 0;
    logic [31:0] m_out = '0;
    bit          m_ovf = 0;
    bit          m_udf = 0;
    bit          m_spur = 0;
    int          m_ovfcnt = 0;

    registro_lectura_resultados #(
        .Width (32),
        .Depth (DEPTH)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .Start          (Start),
        .Done           (Done),
        .Resultado      (Resultado),
        .Read           (Read),
        .Address        (Address),
        .OutDatoMemoria (OutDatoMemoria),
        .ReadValid      (ReadValid),
        .ResetStart     (ResetStart),
        .Busy           (Busy),
        .Irq            (Irq)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; returns after the following negedge so the
    // outputs reflect the edge that sampled these inputs.
    task automatic applyStimulus(input logic rst, input logic st, input logic dn,
                                 input logic [31:0] res, input logic rd, input logic [8:0] addr);
        Reset     = rst;
        Start     = st;
        Done      = dn;
        Resultado = res;
        Read      = rd;
        Address   = addr;
        @(negedge CLK);
    endtask

    task automatic compute(input logic [31:0] val);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, val, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic readReg(input logic [8:0] addr);
        applyStimulus(0, 0, 0, 0, 1, addr);
    endtask

    // Behavioural model stepped on every rising edge, then compared 1 ns later.
    always @(posedge CLK) begin
        logic [31:0] rdv;
        bit is_res;
        bit pop_ok;
        bit ovf_ev;
        bit udf_ev;
        bit spur_ev;
        bit push_req;
        bit clr_stat;
        if (Reset) begin
            q.delete();
            m_phase = 0; m_prev = 0; m_busy = 0; m_rs = 0; m_rv = 0;
            m_out = '0; m_ovf = 0; m_udf = 0; m_spur = 0; m_ovfcnt = 0;
        end else begin
            rdv = '0;
            if (Read) begin
                case (Address)
                    9'h040: rdv = {26'd0, m_spur, m_udf, m_ovf, (q.size() == DEPTH), (q.size() != 0), m_busy};
                    9'h041: rdv = (q.size() != 0) ? q[0] : 32'd0;
                    9'h042: rdv = (q.size() != 0) ? q[0] : 32'd0;
                    9'h043: rdv = q.size();
                    9'h044: rdv = m_ovfcnt;
                    default: rdv = '0;
                endcase
            end
            is_res   = Read && (Address == 9'h041);
            clr_stat = Read && (Address == 9'h040);
            pop_ok   = is_res && (q.size() != 0);
            udf_ev   = is_res && (q.size() == 0);
            push_req = (m_phase == 1) && Done;
            spur_ev  = Done && (m_phase != 1);
            ovf_ev   = 0;
            if (pop_ok) void'(q.pop_front());
            if (push_req) begin
                if (q.size() < DEPTH) q.push_back(Resultado);
                else ovf_ev = 1;
            end
            m_ovf  = ovf_ev  || (m_ovf  && !clr_stat);
            m_udf  = udf_ev  || (m_udf  && !clr_stat);
            m_spur = spur_ev || (m_spur && !clr_stat);
            if (Read && (Address == 9'h044)) m_ovfcnt = ovf_ev ? 1 : 0;
            else if (ovf_ev && m_ovfcnt < 255) m_ovfcnt = m_ovfcnt + 1;
            if (m_phase == 0) begin
                if (Start && !m_prev) m_phase = 1;
            end else if (m_phase == 1) begin
                if (Done) m_phase = 2;
                else if (!Start) m_phase = 0;
            end else begin
                m_phase = 0;
            end
            m_prev = Start;
            m_busy = (m_phase != 0);
            m_rs   = (m_phase == 2);
            if (Read) m_out = rdv;
            m_rv = Read;
        end
        #1;
        if (chk_en) begin
            checkOutput("model OutDatoMemoria", OutDatoMemoria, m_out);
            checkOutput("model ReadValid", {31'd0, ReadValid}, {31'd0, m_rv});
            checkOutput("model ResetStart", {31'd0, ResetStart}, {31'd0, m_rs});
            checkOutput("model Busy", {31'd0, Busy}, {31'd0, m_busy});
            checkOutput("model Irq", {31'd0, Irq},
                        {31'd0, (q.size() != 0) || m_ovf || m_udf || m_spur});
        end
    end

    initial begin
        logic [8:0] addr_tbl [8];
        logic       st_lvl;
        addr_tbl = '{9'h040, 9'h041, 9'h042, 9'h043, 9'h044, 9'h000, 9'h045, 9'h140};

        @(negedge CLK);
        applyStimulus(1, 0, 0, 0, 0, 0);
        chk_en = 1;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset OutDatoMemoria", OutDatoMemoria, 32'd0);
        checkOutput("reset flags", {28'd0, ReadValid, ResetStart, Busy, Irq}, 32'd0);

        // Basic computation with a negative result
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("run Busy", {31'd0, Busy}, 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'hFFFF_FFFB, 0, 0);
        checkOutput("capture ResetStart", {31'd0, ResetStart}, 32'd1);
        checkOutput("capture Irq", {31'd0, Irq}, 32'd1);
        applyStimulus(0, 1, 0, 0, 1, 9'h043);
        checkOutput("count after capture", OutDatoMemoria, 32'd1);
        checkOutput("ResetStart single pulse", {31'd0, ResetStart}, 32'd0);
        checkOutput("Busy low after release", {31'd0, Busy}, 32'd0);
        applyStimulus(0, 1, 0, 0, 1, 9'h041);
        checkOutput("result -5", OutDatoMemoria, 32'hFFFF_FFFB);
        checkOutput("result ReadValid", {31'd0, ReadValid}, 32'd1);
        checkOutput("held Start no retrigger", {31'd0, Busy}, 32'd0);
        readReg(9'h043);
        checkOutput("count after pop", OutDatoMemoria, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ReadValid idle", {31'd0, ReadValid}, 32'd0);

        // Overflow after five computations
        for (int i = 1; i <= 5; i++) compute(32'd100 + i);
        readReg(9'h043);
        checkOutput("count full", OutDatoMemoria, 32'd4);
        readReg(9'h040);
        checkOutput("status full+ovf", OutDatoMemoria, 32'h0000_000E);
        readReg(9'h044);
        checkOutput("ovfcount one", OutDatoMemoria, 32'd1);
        readReg(9'h040);
        checkOutput("status ovf cleared", OutDatoMemoria, 32'h0000_0006);
        readReg(9'h044);
        checkOutput("ovfcount cleared", OutDatoMemoria, 32'd0);

        // Overflow counter saturation
        for (int i = 0; i < 260; i++) compute(32'hDEAD_0000 + i);
        readReg(9'h044);
        checkOutput("ovfcount saturates", OutDatoMemoria, 32'd255);
        readReg(9'h040);
        checkOutput("status after saturation", OutDatoMemoria, 32'h0000_000E);

        // Full FIFO: push and pop in the same cycle
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h8000_0001, 1, 9'h041);
        checkOutput("pop oldest while full", OutDatoMemoria, 32'd101);
        readReg(9'h043);
        checkOutput("count stays full", OutDatoMemoria, 32'd4);
        readReg(9'h040);
        checkOutput("no overflow on push+pop", OutDatoMemoria, 32'h0000_0006);
        readReg(9'h042);
        checkOutput("peek head", OutDatoMemoria, 32'd102);
        readReg(9'h041);
        checkOutput("drain 102", OutDatoMemoria, 32'd102);
        readReg(9'h041);
        checkOutput("drain 103", OutDatoMemoria, 32'd103);
        readReg(9'h041);
        checkOutput("drain 104", OutDatoMemoria, 32'd104);
        readReg(9'h041);
        checkOutput("drain new value", OutDatoMemoria, 32'h8000_0001);

        // Underflow
        readReg(9'h041);
        checkOutput("empty read data", OutDatoMemoria, 32'd0);
        checkOutput("underflow Irq", {31'd0, Irq}, 32'd1);
        readReg(9'h042);
        checkOutput("peek empty", OutDatoMemoria, 32'd0);
        readReg(9'h040);
        checkOutput("status underflow", OutDatoMemoria, 32'h0000_0010);
        readReg(9'h040);
        checkOutput("status underflow cleared", OutDatoMemoria, 32'h0000_0000);
        checkOutput("Irq clear", {31'd0, Irq}, 32'd0);

        // Spurious Done while idle
        applyStimulus(0, 0, 1, 32'h1234_5678, 0, 0);
        checkOutput("spurious no ResetStart", {31'd0, ResetStart}, 32'd0);
        checkOutput("spurious Irq", {31'd0, Irq}, 32'd1);
        readReg(9'h040);
        checkOutput("status spurious", OutDatoMemoria, 32'h0000_0020);

        // Reset in the middle of a computation
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("run before reset", {31'd0, Busy}, 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset mid-run flags", {28'd0, ReadValid, ResetStart, Busy, Irq}, 32'd0);
        applyStimulus(0, 0, 1, 32'h5555_5555, 0, 0);
        checkOutput("Done after reset no ResetStart", {31'd0, ResetStart}, 32'd0);
        readReg(9'h043);
        checkOutput("count after reset", OutDatoMemoria, 32'd0);
        readReg(9'h040);
        checkOutput("status after reset", OutDatoMemoria, 32'h0000_0020);

        // Randomized traffic against the model
        st_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) st_lvl = ~st_lvl;
            applyStimulus(($urandom_range(0, 199) == 0),
                          st_lvl,
                          ($urandom_range(0, 4) == 0),
                          $urandom,
                          ($urandom_range(0, 2) == 0),
                          addr_tbl[$urandom_range(0, 7)]);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
